// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the SPI baud generator block.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_RUN  = 2'b00,
    SPI_WAIT = 2'b01,
    SPI_STOP = 2'b10
  } spi_mode_e;

  localparam int SPI_DIV_W          = 12;
  localparam int SPI_CNT_W          = 11;
  localparam int SPI_BITS_PER_FRAME = 8;
  localparam int SPI_EDGES_PER_FRAME = 2 * SPI_BITS_PER_FRAME;

endpackage

// File: rtl/spi_edge_counter.sv
// Counts emitted sclk edges in a frame, saturating at a full frame; used only
// when the SPI_BAUD_EDGE_CNT_EN build option is enabled.
module spi_edge_counter
  import spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       active_i,
  input  logic       edge_i,
  output logic [4:0] edge_cnt_o,
  output logic       xfer_done_o
);

  localparam logic [4:0] LAST_EDGE = 5'(SPI_EDGES_PER_FRAME);

  logic [4:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!active_i) begin
      cnt_d = '0;
    end else if (edge_i && (cnt_q != LAST_EDGE)) begin
      cnt_d  = cnt_q + 5'd1;
      done_d = (cnt_q == LAST_EDGE - 5'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign edge_cnt_o  = cnt_q;
  assign xfer_done_o = done_q;

endmodule

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator with registered sample/shift strobes.
// Build option SPI_BAUD_EDGE_CNT_EN adds per-frame edge counting (edge_cnt, xfer_done).
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W,
  parameter int CNT_W = SPI_CNT_W
) (
  input  logic             Pclk,
  input  logic             Presetn,
  input  logic [1:0]       spi_mode,
  input  logic             spiswai,
  input  logic [2:0]       sppr,
  input  logic [2:0]       spr,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             ss,
`ifdef SPI_BAUD_EDGE_CNT_EN
  output logic [4:0]       edge_cnt,
  output logic             xfer_done,
`endif
  output logic             sclk,
  output logic [DIV_W-1:0] baud_rate_divisor,
  output logic             sample_strobe,
  output logic             shift_strobe
);

  logic [CNT_W-1:0] half, limit;
  logic             active, frame_hold, edge_fire;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             cpol_q, cpol_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;

  assign half              = (CNT_W'(sppr) + CNT_W'(1)) << spr;
  assign limit             = half - CNT_W'(1);
  assign baud_rate_divisor = DIV_W'(half) << 1;

  // Mode 2'b11 falls through to inactive, same as STOP.
  assign active = !ss && ((spi_mode == SPI_RUN) ||
                          ((spi_mode == SPI_WAIT) && !spiswai));

  assign edge_fire = active && !frame_hold && (cnt_q >= limit);

`ifdef SPI_BAUD_EDGE_CNT_EN
  spi_edge_counter u_edge_counter (
    .clk_i       (Pclk),
    .rst_ni      (Presetn),
    .active_i    (active),
    .edge_i      (edge_fire),
    .edge_cnt_o  (edge_cnt),
    .xfer_done_o (xfer_done)
  );
  assign frame_hold = (edge_cnt == 5'(SPI_EDGES_PER_FRAME));
`else
  assign frame_hold = 1'b0;
`endif

  // cpol_q freezes the idle level for edge classification while a transfer runs.
  always_comb begin
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    cpol_d   = cpol_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    if (!active) begin
      cnt_d  = '0;
      sclk_d = cpol;
      cpol_d = cpol;
    end else if (frame_hold) begin
      cnt_d = '0;
    end else if (edge_fire) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      if ((sclk_q == cpol_q) != cpha) sample_d = 1'b1;
      else                            shift_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      cnt_q    <= '0;
      sclk_q   <= cpol;
      cpol_q   <= cpol;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      cpol_q   <= cpol_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
    end
  end

  assign sclk          = sclk_q;
  assign sample_strobe = sample_q;
  assign shift_strobe  = shift_q;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Scoreboard bench for spi_baud_generator: a phase-timing reference model
// predicts each cycle's outputs; a monitor compares them after each Pclk rise.
module tb_spi_baud_generator;

  logic        Pclk = 1'b0;
  logic        Presetn, spiswai, cpol, cpha, ss;
  logic [1:0]  spi_mode;
  logic [2:0]  sppr, spr;
  logic        sclk, sample_strobe, shift_strobe;
  logic [11:0] baud_rate_divisor;
`ifdef SPI_BAUD_EDGE_CNT_EN
  logic [4:0]  edge_cnt;
  logic        xfer_done;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Pclk = ~Pclk;

  spi_baud_generator dut (
    .Pclk              (Pclk),
    .Presetn           (Presetn),
    .spi_mode          (spi_mode),
    .spiswai           (spiswai),
    .sppr              (sppr),
    .spr               (spr),
    .cpol              (cpol),
    .cpha              (cpha),
    .ss                (ss),
`ifdef SPI_BAUD_EDGE_CNT_EN
    .edge_cnt          (edge_cnt),
    .xfer_done         (xfer_done),
`endif
    .sclk              (sclk),
    .baud_rate_divisor (baud_rate_divisor),
    .sample_strobe     (sample_strobe),
    .shift_strobe      (shift_strobe)
  );

  typedef struct {
    bit sclk;
    bit sample;
    bit shift;
    int div;
    int ecnt;
    bit done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: time spent in the current sclk phase versus the
  // programmed half period; edges counted per frame.
  bit m_sclk;
  bit m_idle_lvl;
  int m_in_phase;
  int m_edges;

  task automatic model_step();
    exp_t e;
    int   half;
    bit   run_mode, act;
    half     = (int'(sppr) + 1) * (1 << spr);
    run_mode = (spi_mode == 2'b00) || (spi_mode == 2'b01 && !spiswai);
    act      = !ss && run_mode;
    e.div    = 2 * half;
    e.sample = 0;
    e.shift  = 0;
    e.done   = 0;
    if (!Presetn || !act) begin
      m_sclk     = cpol;
      m_idle_lvl = cpol;
      m_in_phase = 0;
      m_edges    = 0;
    end else if (m_edges >= 16) begin
      m_in_phase = 0;
    end else if (m_in_phase + 1 >= half) begin
      // Leading edge leaves the idle level; cpha picks which strobe it carries.
      if ((m_sclk == m_idle_lvl) == (cpha == 0)) e.sample = 1;
      else                                       e.shift  = 1;
      m_sclk     = !m_sclk;
      m_in_phase = 0;
      m_edges    = m_edges + 1;
      e.done     = (m_edges == 16);
    end else begin
      m_in_phase = m_in_phase + 1;
    end
`ifndef SPI_BAUD_EDGE_CNT_EN
    if (m_edges >= 16) m_edges = 0;
    e.done = 0;
`endif
    e.sclk = m_sclk;
    e.ecnt = m_edges;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      model_step();
      @(negedge Pclk);
    end
  endtask

  task automatic check_div(input string name, input int want);
    #1;
    total++;
    if (int'(baud_rate_divisor) != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, baud_rate_divisor, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (sclk !== e.sclk || sample_strobe !== e.sample ||
            shift_strobe !== e.shift || int'(baud_rate_divisor) != e.div) begin
          bad++;
          $display("FAIL cycle@%0t: got sclk=%b smp=%b shf=%b div=%0d, want sclk=%b smp=%b shf=%b div=%0d",
                   $time, sclk, sample_strobe, shift_strobe, baud_rate_divisor,
                   e.sclk, e.sample, e.shift, e.div);
        end
        if (sample_strobe && shift_strobe) begin
          bad++;
          $display("FAIL strobe_overlap@%0t: got both strobes high, want at most one", $time);
        end
`ifdef SPI_BAUD_EDGE_CNT_EN
        total++;
        if (int'(edge_cnt) != e.ecnt || xfer_done !== e.done) begin
          bad++;
          $display("FAIL edgecnt@%0t: got cnt=%0d done=%b, want cnt=%0d done=%b",
                   $time, edge_cnt, xfer_done, e.ecnt, e.done);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    Presetn = 0; spi_mode = 2'b00; spiswai = 0;
    sppr = 0; spr = 0; cpol = 0; cpha = 0; ss = 1;
    m_sclk = 0; m_idle_lvl = 0; m_in_phase = 0; m_edges = 0;
    cyc(2);
    // half=1: toggle every cycle, strobes alternate
    Presetn = 1; ss = 0;
    check_div("div_min", 2);
    cyc(24);
    // half=6, cpol/cpha=1, idle change while inactive
    ss = 1; sppr = 2; spr = 1; cpol = 1; cpha = 1;
    check_div("div_12", 12);
    cyc(3);
    ss = 0;
    cyc(40);
    // ss rise mid-phase then restart
    ss = 1; cyc(1); ss = 0; cyc(3); ss = 1; cyc(1); ss = 0; cyc(20);
    // WAIT/STOP handling
    spi_mode = 2'b01; spiswai = 1; cyc(10);
    spiswai = 0; cyc(20);
    spi_mode = 2'b10; cyc(8); spiswai = 1; cyc(4);
    spi_mode = 2'b11; spiswai = 0; cyc(5);
    spi_mode = 2'b00; cyc(10);
    // shrink half from 1024 to 1 mid-phase
    ss = 1; sppr = 7; spr = 7; cpol = 0; cpha = 0;
    check_div("div_max", 2048);
    cyc(2);
    ss = 0; cyc(500);
    sppr = 0; spr = 0; cyc(10);
    // reset mid-transfer
    sppr = 1; spr = 0; cyc(7);
    Presetn = 0; cyc(1); Presetn = 1; cyc(12);
    // full frame with a fresh ss
    ss = 1; cyc(2); ss = 0; sppr = 0; spr = 1; cyc(80);
    ss = 1; cyc(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ss = ~ss;
      if ($urandom_range(0, 59) == 0) spi_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) spiswai = ~spiswai;
      if ($urandom_range(0, 49) == 0) begin
        sppr = 3'($urandom_range(0, 7));
        spr  = 3'($urandom_range(0, 2));
      end
      if (ss && $urandom_range(0, 3) == 0) begin
        cpol = 1'($urandom_range(0, 1));
        cpha = 1'($urandom_range(0, 1));
      end
      Presetn = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    Presetn = 1; ss = 1;
    cyc(2);
    @(negedge Pclk);
    @(negedge Pclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
